// File: rtl/reg_shift_sequencer_pkg.sv
// Shared ISA definitions for the register-specified shift sequencer:
// shift-type encodings, operand widths and sequencer state encodings.
package reg_shift_sequencer_pkg;

  localparam int LEN_ADDRESS      = 32;
  localparam int LEN_SHIFT_AMOUNT = 8;
  localparam int LEN_COUNT        = 6;

  localparam logic [1:0] STATE_LSL_SHIFT = 2'b00;
  localparam logic [1:0] STATE_LSR_SHIFT = 2'b01;
  localparam logic [1:0] STATE_ASR_SHIFT = 2'b10;
  localparam logic [1:0] STATE_ROR_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_SHIFT = 2'd1,
    SEQ_DONE  = 2'd2
  } seq_state_t;

  // Bit positions the datapath must actually move; ROR wraps modulo 32.
  function automatic logic [LEN_COUNT-1:0] eff_count(
    input logic [1:0]                  shift_type,
    input logic [LEN_SHIFT_AMOUNT-1:0] amount
  );
    if (shift_type == STATE_ROR_SHIFT) return {1'b0, amount[4:0]};
    if (amount > 8'd32) return 6'd32;
    return amount[LEN_COUNT-1:0];
  endfunction

endpackage

// File: rtl/reg_shift_sequencer_shift_step.sv
// Combinational partial shifter: moves value by k (0..32) positions of the
// selected type and reports the last bit shifted out.
module shift_step
  import reg_shift_sequencer_pkg::*;
(
  input  logic [LEN_ADDRESS-1:0] value_i,
  input  logic [1:0]             type_i,
  input  logic [LEN_COUNT-1:0]   k_i,
  input  logic                   carry_i,
  output logic [LEN_ADDRESS-1:0] value_o,
  output logic                   carry_o
);

  logic [2*LEN_ADDRESS-1:0] wide;

  // Shifting inside a 64-bit window keeps k = 32 well defined for every type.
  always_comb begin
    wide    = '0;
    value_o = value_i;
    carry_o = carry_i;
    if (k_i != '0) begin
      case (type_i)
        STATE_LSL_SHIFT: begin
          wide    = {32'b0, value_i} << k_i;
          value_o = wide[31:0];
          carry_o = wide[32];
        end
        STATE_LSR_SHIFT: begin
          wide    = {value_i, 32'b0} >> k_i;
          value_o = wide[63:32];
          carry_o = wide[31];
        end
        STATE_ASR_SHIFT: begin
          wide    = 64'($signed({value_i, 32'b0}) >>> k_i);
          value_o = wide[63:32];
          carry_o = wide[31];
        end
        default: begin
          wide    = {value_i, value_i} >> k_i;
          value_o = wide[31:0];
          carry_o = wide[31];
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_shift_sequencer.sv
// Multi-cycle register-specified shift controller: latches operands on start,
// shifts up to STEP positions per cycle, then applies ARM boundary overrides.
//
//   state     | meaning
//   SEQ_IDLE  | waiting for start; outputs hold last result
//   SEQ_SHIFT | partial shifts in progress, rem positions left
//   SEQ_DONE  | shifting finished; next edge publishes result and done
module reg_shift_sequencer
  import reg_shift_sequencer_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   flush,
  input  logic [1:0]             shift_type,
  input  logic [LEN_ADDRESS-1:0] rm_val,
  input  logic [LEN_ADDRESS-1:0] rs_val,
  input  logic                   carry_in,
  output logic [LEN_ADDRESS-1:0] result,
  output logic                   carry_out,
  output logic                   busy,
  output logic                   done
);

  localparam logic [LEN_COUNT-1:0] STEP_C = LEN_COUNT'(STEP);

  seq_state_t                  state_q, state_d;
  logic [1:0]                  type_q, type_d;
  logic [LEN_SHIFT_AMOUNT-1:0] amt_q, amt_d;
  logic [LEN_ADDRESS-1:0]      rm_q, rm_d;
  logic                        cin_q, cin_d;
  logic [LEN_ADDRESS-1:0]      val_q, val_d;
  logic                        car_q, car_d;
  logic [LEN_COUNT-1:0]        rem_q, rem_d;
  logic [LEN_ADDRESS-1:0]      result_q, result_d;
  logic                        carry_q, carry_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [LEN_COUNT-1:0]        step_k;
  logic [LEN_COUNT-1:0]        start_n;
  logic [LEN_ADDRESS-1:0]      step_val;
  logic                        step_car;
  logic [LEN_ADDRESS-1:0]      fin_val;
  logic                        fin_car;
  logic                        rs_unused;

  assign rs_unused = ^rs_val[LEN_ADDRESS-1:LEN_SHIFT_AMOUNT];
  assign step_k    = (rem_q < STEP_C) ? rem_q : STEP_C;
  assign start_n   = eff_count(shift_type, rs_val[LEN_SHIFT_AMOUNT-1:0]);

  shift_step u_shift_step (
    .value_i (val_q),
    .type_i  (type_q),
    .k_i     (step_k),
    .carry_i (car_q),
    .value_o (step_val),
    .carry_o (step_car)
  );

  // Amounts the clamped datapath cannot express exactly are fixed up here.
  always_comb begin
    fin_val = val_q;
    fin_car = car_q;
    if (amt_q == '0) begin
      fin_val = rm_q;
      fin_car = cin_q;
    end else begin
      case (type_q)
        STATE_LSL_SHIFT: begin
          if (amt_q > 8'd32) begin
            fin_val = '0;
            fin_car = 1'b0;
          end else if (amt_q == 8'd32) begin
            fin_val = '0;
            fin_car = rm_q[0];
          end
        end
        STATE_LSR_SHIFT: begin
          if (amt_q > 8'd32) begin
            fin_val = '0;
            fin_car = 1'b0;
          end else if (amt_q == 8'd32) begin
            fin_val = '0;
            fin_car = rm_q[31];
          end
        end
        STATE_ASR_SHIFT: begin
          if (amt_q >= 8'd32) begin
            fin_val = {LEN_ADDRESS{rm_q[31]}};
            fin_car = rm_q[31];
          end
        end
        default: begin
          if (amt_q[4:0] == 5'd0) begin
            fin_val = rm_q;
            fin_car = rm_q[31];
          end
        end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    amt_d    = amt_q;
    rm_d     = rm_q;
    cin_d    = cin_q;
    val_d    = val_q;
    car_d    = car_q;
    rem_d    = rem_q;
    result_d = result_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (start && !flush) begin
          type_d  = shift_type;
          amt_d   = rs_val[LEN_SHIFT_AMOUNT-1:0];
          rm_d    = rm_val;
          cin_d   = carry_in;
          val_d   = rm_val;
          car_d   = carry_in;
          rem_d   = start_n;
          state_d = (start_n == '0) ? SEQ_DONE : SEQ_SHIFT;
        end
      end
      SEQ_SHIFT: begin
        if (flush) begin
          state_d = SEQ_IDLE;
        end else begin
          val_d = step_val;
          car_d = step_car;
          rem_d = rem_q - step_k;
          if (rem_q <= STEP_C) state_d = SEQ_DONE;
        end
      end
      SEQ_DONE: begin
        state_d = SEQ_IDLE;
        if (!flush) begin
          result_d = fin_val;
          carry_d  = fin_car;
          done_d   = 1'b1;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    busy_d = (state_d != SEQ_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SEQ_IDLE;
      type_q   <= STATE_LSL_SHIFT;
      amt_q    <= '0;
      rm_q     <= '0;
      cin_q    <= 1'b0;
      val_q    <= '0;
      car_q    <= 1'b0;
      rem_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      amt_q    <= amt_d;
      rm_q     <= rm_d;
      cin_q    <= cin_d;
      val_q    <= val_d;
      car_q    <= car_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
